keynsham_irq_ctrl: RTL and testbench

//  Interrupt controller directly downstream of the timer block and other peripherals.

---
 rtl/keynsham_irq_pkg.sv | 33 +++
 rtl/cs_gen.sv | 21 ++
 rtl/keynsham_irq_ctrl_prio_enc.sv | 20 ++
 rtl/keynsham_irq_ctrl.sv | 161 ++++++++++++++++
 tb/tb_keynsham_irq_ctrl.sv | 235 +++++++++++++++++++++++
 5 files changed

// File: rtl/keynsham_irq_pkg.sv
// Shared register map, HIGHEST field layout and small helpers for the keynsham interrupt
// controller. The optional TEST register is enabled by defining KEYNSHAM_IRQ_TEST_EN.
package keynsham_irq_pkg;

    localparam logic [2:0] IRQ_REG_STATUS  = 3'd0;
    localparam logic [2:0] IRQ_REG_RAW     = 3'd1;
    localparam logic [2:0] IRQ_REG_ENSET   = 3'd2;
    localparam logic [2:0] IRQ_REG_ENCLR   = 3'd3;
    localparam logic [2:0] IRQ_REG_CLEAR   = 3'd4;
    localparam logic [2:0] IRQ_REG_TEST    = 3'd5;
    localparam logic [2:0] IRQ_REG_HIGHEST = 3'd6;

    localparam int unsigned IRQ_HIGHEST_VALID_BIT = 31;
    localparam int unsigned IRQ_HIGHEST_IDX_W     = 5;

    typedef struct packed {
        logic                         valid;
        logic [IRQ_HIGHEST_IDX_W-1:0] idx;
    } irq_prio_t;

    function automatic logic [31:0] irq_byte_mask(input logic [3:0] bytesel);
        return {{8{bytesel[3]}}, {8{bytesel[2]}}, {8{bytesel[1]}}, {8{bytesel[0]}}};
    endfunction

    function automatic logic [31:0] irq_highest_word(input irq_prio_t prio);
        logic [31:0] word;
        word = '0;
        word[IRQ_HIGHEST_VALID_BIT] = prio.valid;
        word[IRQ_HIGHEST_IDX_W-1:0] = prio.idx;
        return word;
    endfunction

endpackage

// File: rtl/cs_gen.sv
// Bus window decoder: asserts cs_o when the word address falls inside
// [address, address + size) expressed in bytes.
module cs_gen #(
    parameter logic [31:0] address = 32'h0,
    parameter logic [31:0] size    = 32'h0
) (
    input  logic [29:0] addr_i,
    output logic        cs_o
);

    logic [32:0] byte_addr;
    logic [32:0] win_lo;
    logic [32:0] win_hi;

    // 33-bit compare so a window touching the top of the address space does not wrap.
    assign byte_addr = {1'b0, addr_i, 2'b00};
    assign win_lo    = {1'b0, address};
    assign win_hi    = {1'b0, address} + {1'b0, size};
    assign cs_o      = (byte_addr >= win_lo) && (byte_addr < win_hi);

endmodule

// File: rtl/keynsham_irq_ctrl_prio_enc.sv
// Combinational priority encoder: lowest-numbered set bit of a 32-bit vector wins.
module keynsham_irq_ctrl_prio_enc
    import keynsham_irq_pkg::*;
(
    input  logic [31:0] active_i,
    output irq_prio_t   prio_o
);

    always_comb begin
        prio_o = '0;
        // Scan downwards so the last hit, the lowest index, is what remains.
        for (int i = 31; i >= 0; i--) begin
            if (active_i[i]) begin
                prio_o.valid = 1'b1;
                prio_o.idx   = IRQ_HIGHEST_IDX_W'(i);
            end
        end
    end

endmodule

// File: rtl/keynsham_irq_ctrl.sv
// Interrupt controller: level/edge pending capture, per-line enables, registered irq_out and
// a bus slave register file. Define KEYNSHAM_IRQ_TEST_EN to add the TEST register.
module keynsham_irq_ctrl
    import keynsham_irq_pkg::*;
#(
    parameter logic [31:0] bus_address = 32'h0,
    parameter logic [31:0] bus_size    = 32'h0,
    parameter int unsigned nr_irqs     = 32,
    parameter logic [31:0] edge_mask   = 32'h0
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               bus_access,
    output logic               bus_cs,
    input  logic [29:0]        bus_addr,
    input  logic [31:0]        bus_wr_val,
    input  logic               bus_wr_en,
    input  logic [3:0]         bus_bytesel,
    output logic               bus_error,
    output logic               bus_ack,
    output logic [31:0]        bus_data,
    input  logic [nr_irqs-1:0] irq_in,
    output logic               irq_out
);

    localparam logic [31:0] ValidMask  = (nr_irqs >= 32) ? 32'hFFFF_FFFF :
                                                           ((32'h1 << nr_irqs) - 32'h1);
    localparam logic [31:0] EdgeLines  = edge_mask & ValidMask;
    localparam logic [31:0] LevelLines = ~edge_mask & ValidMask;

    logic [nr_irqs-1:0] irq_in_q;
    logic [31:0]        irq_in_ext;
    logic [31:0]        irq_prev_q;
    logic [31:0]        edge_pend_q, edge_pend_d;
    logic [31:0]        enable_q, enable_d;
    logic [31:0]        test, test_set;
    logic [31:0]        pending, active;
    logic               bus_ack_q, bus_error_q, irq_out_q;
    logic [31:0]        bus_data_q;

    logic               acc, wr_acc, unmapped;
    logic [2:0]         offset;
    logic [31:0]        byte_mask, wmask, rd_data;
    irq_prio_t          prio;

    cs_gen #(
        .address (bus_address),
        .size    (bus_size)
    ) u_cs_gen (
        .addr_i (bus_addr),
        .cs_o   (bus_cs)
    );

    keynsham_irq_ctrl_prio_enc u_prio_enc (
        .active_i (active),
        .prio_o   (prio)
    );

    assign acc       = bus_access & bus_cs;
    assign wr_acc    = acc & bus_wr_en;
    assign offset    = bus_addr[2:0];
    assign byte_mask = irq_byte_mask(bus_bytesel);
    assign wmask     = bus_wr_val & byte_mask & ValidMask;

`ifdef KEYNSHAM_IRQ_TEST_EN
    logic [31:0] test_q, test_d;
    logic        test_wr;

    assign test_wr  = wr_acc && (offset == IRQ_REG_TEST);
    assign test     = test_q;
    assign test_set = test_wr ? wmask : 32'h0;
    assign unmapped = (offset == 3'd7);

    always_comb begin
        test_d = test_q;
        if (test_wr) begin
            test_d = ((test_q & ~byte_mask) | (bus_wr_val & byte_mask)) & ValidMask;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            test_q <= '0;
        end else begin
            test_q <= test_d;
        end
    end
`else
    assign test     = 32'h0;
    assign test_set = 32'h0;
    assign unmapped = (offset == 3'd7) || (offset == IRQ_REG_TEST);
`endif

    always_comb begin
        irq_in_ext              = '0;
        irq_in_ext[nr_irqs-1:0] = irq_in_q;
    end

    assign pending = ((irq_in_ext | test) & LevelLines) | edge_pend_q;
    assign active  = pending & enable_q;

    always_comb begin
        enable_d    = enable_q;
        edge_pend_d = edge_pend_q;
        if (wr_acc && (offset == IRQ_REG_ENSET)) begin
            enable_d = enable_d | wmask;
        end
        if (wr_acc && (offset == IRQ_REG_ENCLR)) begin
            enable_d = enable_d & ~wmask;
        end
        if (wr_acc && (offset == IRQ_REG_CLEAR)) begin
            edge_pend_d = edge_pend_d & ~wmask;
        end
        // Sets are applied after the clear so a same-cycle edge survives.
        edge_pend_d = (edge_pend_d | (irq_in_ext & ~irq_prev_q) | test_set) & EdgeLines;
    end

    always_comb begin
        rd_data = 32'h0;
        case (offset)
            IRQ_REG_STATUS:  rd_data = active;
            IRQ_REG_RAW:     rd_data = pending;
            IRQ_REG_ENSET:   rd_data = enable_q;
            IRQ_REG_ENCLR:   rd_data = enable_q;
            IRQ_REG_TEST:    rd_data = test;
            IRQ_REG_HIGHEST: rd_data = irq_highest_word(prio);
            default:         rd_data = 32'h0;
        endcase
        if (unmapped) begin
            rd_data = 32'h0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            irq_in_q    <= '0;
            irq_prev_q  <= '0;
            edge_pend_q <= '0;
            enable_q    <= '0;
            irq_out_q   <= 1'b0;
            bus_ack_q   <= 1'b0;
            bus_error_q <= 1'b0;
            bus_data_q  <= '0;
        end else begin
            irq_in_q    <= irq_in;
            irq_prev_q  <= irq_in_ext;
            edge_pend_q <= edge_pend_d;
            enable_q    <= enable_d;
            irq_out_q   <= |active;
            bus_ack_q   <= acc;
            bus_error_q <= acc & unmapped;
            bus_data_q  <= acc ? rd_data : 32'h0;
        end
    end

    assign bus_ack   = bus_ack_q;
    assign bus_error = bus_error_q;
    assign bus_data  = bus_data_q;
    assign irq_out   = irq_out_q;

endmodule

// File: tb/tb_keynsham_irq_ctrl.sv
// Self-checking bench for keynsham_irq_ctrl: directed scenarios then random traffic, all
// compared every cycle against a behavioural model of the register map.
module tb_keynsham_irq_ctrl;

    localparam logic [31:0] Base  = 32'h0000_0100;
    localparam logic [31:0] Size  = 32'h0000_0020;
    localparam logic [31:0] Edges = 32'hFFFF_00F2;
    localparam logic [29:0] WBase = 30'h40;
`ifdef KEYNSHAM_IRQ_TEST_EN
    localparam bit HasTest = 1'b1;
`else
    localparam bit HasTest = 1'b0;
`endif

    logic        clk = 1'b0;
    logic        rst, bus_access, bus_cs, bus_wr_en, bus_error, bus_ack, irq_out;
    logic [29:0] bus_addr;
    logic [31:0] bus_wr_val, bus_data, irq_in;
    logic [3:0]  bus_bytesel;

    int unsigned n_checks = 0;
    int unsigned n_fails  = 0;

    // Model state.
    logic [31:0] m_in_q, m_prev, m_pend, m_en, m_test;

    keynsham_irq_ctrl #(
        .bus_address (Base),
        .bus_size    (Size),
        .nr_irqs     (32),
        .edge_mask   (Edges)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .bus_access  (bus_access),
        .bus_cs      (bus_cs),
        .bus_addr    (bus_addr),
        .bus_wr_val  (bus_wr_val),
        .bus_wr_en   (bus_wr_en),
        .bus_bytesel (bus_bytesel),
        .bus_error   (bus_error),
        .bus_ack     (bus_ack),
        .bus_data    (bus_data),
        .irq_in      (irq_in),
        .irq_out     (irq_out)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] model_pending();
        return ((m_in_q | m_test) & ~Edges) | m_pend;
    endfunction

    function automatic logic [31:0] model_highest(input logic [31:0] act);
        for (int i = 0; i < 32; i++) begin
            if (act[i]) return 32'h8000_0000 | i;
        end
        return 32'h0;
    endfunction

    // One clock: drive inputs, predict, cross the edge, compare all outputs.
    task automatic tick(input bit r, input bit acc, input bit wr, input logic [29:0] a,
                        input logic [31:0] wd, input logic [3:0] bs, input logic [31:0] irq);
        logic [32:0] ba;
        logic        win, access, err;
        logic [31:0] pend, act, rd, bm, wm, e_data;
        logic        e_ack, e_err, e_irq;
        rst = r; bus_access = acc; bus_wr_en = wr; bus_addr = a;
        bus_wr_val = wd; bus_bytesel = bs; irq_in = irq;
        #1;
        ba  = {1'b0, a, 2'b00};
        win = (ba >= {1'b0, Base}) && (ba < ({1'b0, Base} + {1'b0, Size}));
        chk("bus_cs", {31'b0, bus_cs}, {31'b0, win});
        access = acc && win;
        pend   = model_pending();
        act    = pend & m_en;
        err    = (a[2:0] == 3'd7) || (a[2:0] == 3'd5 && !HasTest);
        case (a[2:0])
            3'd0: rd = act;
            3'd1: rd = pend;
            3'd2, 3'd3: rd = m_en;
            3'd5: rd = HasTest ? m_test : 32'h0;
            3'd6: rd = model_highest(act);
            default: rd = 32'h0;
        endcase
        e_ack  = !r && access;
        e_err  = !r && access && err;
        e_data = (!r && access && !err) ? rd : 32'h0;
        e_irq  = !r && (act != 0);
        bm = {{8{bs[3]}}, {8{bs[2]}}, {8{bs[1]}}, {8{bs[0]}}};
        wm = (access && wr) ? (wd & bm) : 32'h0;
        if (r) begin
            m_in_q = 0; m_prev = 0; m_pend = 0; m_en = 0; m_test = 0;
        end else begin
            logic [31:0] clr, tset;
            clr  = (a[2:0] == 3'd4) ? wm : 32'h0;
            tset = (HasTest && a[2:0] == 3'd5) ? wm : 32'h0;
            m_pend = ((m_pend & ~clr) | (m_in_q & ~m_prev) | tset) & Edges;
            if (a[2:0] == 3'd2) m_en = m_en | wm;
            if (a[2:0] == 3'd3) m_en = m_en & ~wm;
            if (HasTest && access && wr && a[2:0] == 3'd5) m_test = (m_test & ~bm) | (wd & bm);
            m_prev = m_in_q;
            m_in_q = irq;
        end
        @(posedge clk);
        #1;
        chk("bus_ack", {31'b0, bus_ack}, {31'b0, e_ack});
        chk("bus_error", {31'b0, bus_error}, {31'b0, e_err});
        chk("bus_data", bus_data, e_data);
        chk("irq_out", {31'b0, irq_out}, {31'b0, e_irq});
    endtask

    task automatic idle(input logic [31:0] irq);
        tick(1'b0, 1'b0, 1'b0, WBase, 32'h0, 4'h0, irq);
    endtask

    task automatic rd_reg(input logic [2:0] off, input logic [31:0] irq);
        tick(1'b0, 1'b1, 1'b0, WBase + 30'(off), 32'h0, 4'h0, irq);
    endtask

    task automatic wr_reg(input logic [2:0] off, input logic [31:0] v, input logic [3:0] bs,
                          input logic [31:0] irq);
        tick(1'b0, 1'b1, 1'b1, WBase + 30'(off), v, bs, irq);
    endtask

    initial begin
        m_in_q = 0; m_prev = 0; m_pend = 0; m_en = 0; m_test = 0;

        // Reset for two cycles, then everything reads back as zero.
        tick(1'b1, 1'b0, 1'b0, WBase, 32'h0, 4'h0, 32'h0);
        tick(1'b1, 1'b0, 1'b0, WBase, 32'h0, 4'h0, 32'h0);
        chk("reset_irq_out", {31'b0, irq_out}, 32'h0);
        chk("reset_bus_ack", {31'b0, bus_ack}, 32'h0);
        rd_reg(3'd2, 32'h0);
        chk("reset_enset", bus_data, 32'h0);
        rd_reg(3'd1, 32'h0);
        chk("reset_raw", bus_data, 32'h0);

        // Level line 0: irq_out follows irq_in two cycles later.
        wr_reg(3'd2, 32'h1, 4'hF, 32'h0);
        idle(32'h1);
        idle(32'h1);
        chk("level_rise", {31'b0, irq_out}, 32'h1);
        idle(32'h0);
        idle(32'h0);
        chk("level_fall", {31'b0, irq_out}, 32'h0);

        // Edge line 1: a one-cycle pulse latches.
        idle(32'h2);
        idle(32'h0);
        idle(32'h0);
        rd_reg(3'd1, 32'h0);
        chk("edge_latch", bus_data, 32'h2);
        idle(32'h2);
        wr_reg(3'd4, 32'h2, 4'hF, 32'h0);
        rd_reg(3'd1, 32'h0);
        chk("edge_set_wins", bus_data, 32'h2);

        // Priority: lines 1 and 3 active.
        wr_reg(3'd3, 32'hFFFF_FFFF, 4'hF, 32'h8);
        wr_reg(3'd2, 32'hF, 4'hF, 32'h8);
        idle(32'h8);
        rd_reg(3'd6, 32'h8);
        chk("highest_1", bus_data, 32'h8000_0001);
        wr_reg(3'd4, 32'h2, 4'hF, 32'h8);
        rd_reg(3'd6, 32'h8);
        chk("highest_3", bus_data, 32'h8000_0003);

        // Byte lanes.
        wr_reg(3'd3, 32'hFFFF_FFFF, 4'hF, 32'h0);
        wr_reg(3'd2, 32'hFFFF_FFFF, 4'b0010, 32'h0);
        rd_reg(3'd2, 32'h0);
        chk("bytesel_enable", bus_data, 32'h0000_FF00);

        // Unmapped offset 7, back-to-back with a following read.
        rd_reg(3'd7, 32'h0);
        chk("err7_ack", {31'b0, bus_ack}, 32'h1);
        chk("err7_error", {31'b0, bus_error}, 32'h1);
        chk("err7_data", bus_data, 32'h0);
        rd_reg(3'd3, 32'h0);
        chk("b2b_ack", {31'b0, bus_ack}, 32'h1);

        // Offset 5.
`ifdef KEYNSHAM_IRQ_TEST_EN
        wr_reg(3'd2, 32'h4, 4'hF, 32'h0);
        wr_reg(3'd5, 32'h4, 4'hF, 32'h0);
        chk("test_ack", {31'b0, bus_error}, 32'h0);
        idle(32'h0);
        chk("test_irq_out", {31'b0, irq_out}, 32'h1);
        wr_reg(3'd5, 32'h0, 4'hF, 32'h0);
        idle(32'h0);
        idle(32'h0);
`else
        wr_reg(3'd5, 32'h4, 4'hF, 32'h0);
        chk("off5_error", {31'b0, bus_error}, 32'h1);
`endif

        // Outside the window: no ack.
        tick(1'b0, 1'b1, 1'b0, WBase + 30'd8, 32'h0, 4'h0, 32'h0);
        chk("outside_ack", {31'b0, bus_ack}, 32'h0);

        // Reset arriving during an access suppresses the ack.
        tick(1'b1, 1'b1, 1'b0, WBase + 30'd2, 32'h0, 4'h0, 32'h0);
        chk("rst_access_ack", {31'b0, bus_ack}, 32'h0);

        // Random traffic.
        begin
            logic [31:0] irq_cur;
            irq_cur = 32'h0;
            for (int n = 0; n < 800; n++) begin
                bit          r, acc, wr;
                logic [29:0] a;
                irq_cur = irq_cur ^ ($urandom & $urandom & $urandom);
                r   = ($urandom_range(0, 99) == 0);
                acc = ($urandom_range(0, 2) != 0);
                wr  = $urandom_range(0, 1) == 1;
                a   = ($urandom_range(0, 9) == 0) ? 30'($urandom) :
                                                    WBase + 30'($urandom_range(0, 7));
                tick(r, acc, wr, a, $urandom, 4'($urandom), irq_cur);
            end
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
